eth_tx_frame_gen: RTL
=====================

// Module: eth_tx_frame_gen
// PURPOSE
//  AXI4-Stream test-frame generator feeding the Ethernet subsystem TX user interface.
//  Driven by the 32-bit config word (scalar00) from the ethernet control register block.
//  Gated by rx_block_lock. Emits fixed-length frames with a deterministic, checkable
//  payload, an inter-frame gap, and a running frame count.
// PARAMETERS
//  DATA_WIDTH  64   tdata width in bits; multiple of 32, range 32..512
//  CNT_WIDTH   32   width of frame_cnt (and stall_cnt when compiled in)
// PORTS
//  ACLK           in   1             single clock; all logic rising-edge
//  ARESETN        in   1             asynchronous, active-low reset
//  cfg            in   32            config word: [0] enable, [15:8] len_beats, [31:16] gap_cycles
//  link_up        in   1             rx_block_lock; a frame may start only while high
//  m_axis_tdata   out  DATA_WIDTH    payload beat
//  m_axis_tkeep   out  DATA_WIDTH/8  byte enables; all ones on every beat
//  m_axis_tvalid  out  1             beat valid
//  m_axis_tlast   out  1             last beat of frame
//  m_axis_tready  in   1             downstream accept
//  busy           out  1             high in SEND or GAP
//  frame_cnt      out  CNT_WIDTH     frames completed (tlast handshakes), wraps to 0
// BEHAVIOUR
//  Reset (async, ARESETN=0):
//   - state=IDLE; tvalid=0, tlast=0, tdata=0, busy=0, frame_cnt=0, internal counters 0.
//   - Takes effect immediately, including mid-frame; no frame resumes after release.
//  FSM IDLE:
//   - cfg[0]=1 && link_up=1 -> SEND next cycle.
//   - Latch len=max(cfg[15:8],1) and gap=cfg[31:16]; beat_idx=0.
//  FSM SEND:
//   - tvalid=1; beat accepted on tvalid&&tready.
//   - tlast=1 exactly when beat_idx==len-1; len=1 gives a single beat with tlast=1.
//   - After the tlast handshake: frame_cnt+=1 and frame_seq+=1.
//   - After the tlast handshake, next state is GAP if gap!=0, else IDLE.
//  FSM GAP:
//   - tvalid=0; counts gap cycles, then -> IDLE.
//   - Back-to-back with gap=0: IDLE->SEND costs one cycle, so each frame has exactly one idle cycle.
//  Data:
//   - tdata = {DATA_WIDTH/32{frame_seq[15:0], beat_idx[15:0]}}; beat_idx is 8-bit zero-extended.
//   - frame_seq is 16-bit, starts at 0, and wraps 0xFFFF->0.
//   - frame_cnt wraps at 2^CNT_WIDTH.
//  AXIS rules:
//   - Once tvalid=1, tdata, tlast and tkeep stay stable and tvalid stays high until tready.
//   - tready is ignored while tvalid=0. No combinational path from tready to tvalid.
//  Config and link changes:
//   - cfg changes are sampled only in IDLE; len and gap are constant for the frame in flight.
//   - cfg[0] falling during SEND or GAP: the current frame and gap complete, then the FSM stays in IDLE.
//   - link_up falling during SEND: the frame still completes (never truncated, tlast always
//     delivered); no new frame starts until link_up=1.
//  Latency:
//   - First tvalid appears 1 cycle after the cycle where enable&&link_up is seen in IDLE.
//   - With tready held high, a frame occupies len cycles.
// CONFIGURATION
//  TX_GEN_STALL_CNT_EN defined:
//   - Adds output stall_cnt [CNT_WIDTH-1:0].
//   - Increments each cycle with tvalid&&!tready; saturates at all ones; reset to 0.
//  TX_GEN_STALL_CNT_EN undefined:
//   - Port stall_cnt and its logic are absent; all other behaviour is identical.
// TESTING
//  T1 basic:
//   - cfg=0x0000_0401, link_up=1, tready=1.
//   - Expect: 4 beats; beat k tdata={0x0000,k} replicated; tlast on k=3; frame_cnt 0->1 at the tlast handshake.
//  T2 backpressure:
//   - cfg=0x0000_0301; tready toggled pseudo-randomly (seed 1).
//   - Expect: data and tlast stable while stalled; exactly 3 accepted beats per frame.
//   - With TX_GEN_STALL_CNT_EN: stall_cnt equals the number of stalled cycles.
//  T3 gap:
//   - cfg=0x0005_0201, tready=1.
//   - Expect: tvalid low for 5 GAP cycles + 1 IDLE cycle between frames.
//   - tdata high half = 0x0001 on the second frame.
//  T4 len=0 and link gating:
//   - cfg=0x0000_0001 with link_up=0 -> no tvalid for 20 cycles.
//   - Raise link_up -> single-beat frames, each with tlast=1.
//  T5 mid-frame events:
//   - cfg=0x0000_0801; drop cfg[0] and link_up at beat 3.
//   - Expect: beats 4..7 still sent with tlast on 7, then IDLE; frame_cnt=1.
//  T6 async reset:
//   - Assert ARESETN=0 at beat 2 of an 8-beat frame.
//   - Expect: tvalid=0 and frame_cnt=0 immediately.
//   - After release with enable=1: a new frame starts at beat 0 with frame_seq=0.

Source files
------------

// File: rtl/eth_tx_frame_gen.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_gen
//   AXI4-Stream test-frame generator for the Ethernet TX user interface.
//   Emits fixed-length frames whose payload encodes {frame_seq, beat_idx},
//   separated by a programmable inter-frame gap, and keeps a running count
//   of completed frames. A frame may only start while link_up is high.
//
// Ports
//   ACLK, ARESETN   clock (rising edge) and asynchronous active-low reset
//   cfg[31:0]       [0] enable, [15:8] len_beats (0 treated as 1),
//                   [31:16] gap_cycles
//   link_up         rx_block_lock; gates the start of a new frame
//   m_axis_*        AXI4-Stream master (tdata/tkeep/tvalid/tlast/tready)
//   busy            high while sending a frame or counting the gap
//   frame_cnt       number of tlast handshakes, wraps
//   stall_cnt       (only with TX_GEN_STALL_CNT_EN) cycles with
//                   tvalid && !tready, saturating
//
// Build option
//   TX_GEN_STALL_CNT_EN  adds the stall_cnt output and its counter.
// -----------------------------------------------------------------------------
module eth_tx_frame_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [31:0]             cfg,
   input  logic                    link_up,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic                    busy,
   output logic [CNT_WIDTH-1:0]    frame_cnt
`ifdef TX_GEN_STALL_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]    stall_cnt
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   logic [1:0]           state_reg;
   logic [7:0]           len_reg;
   logic [15:0]          gap_reg;
   logic [7:0]           beat_idx_reg;
   logic [15:0]          gap_cnt_reg;
   logic [15:0]          frame_seq_reg;
   logic [CNT_WIDTH-1:0] frame_cnt_reg;
   logic                 last_beat;

   assign last_beat = (beat_idx_reg == len_reg - 8'd1);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_reg     <= IDLE;
         len_reg       <= 8'd1;
         gap_reg       <= 16'd0;
         beat_idx_reg  <= 8'd0;
         gap_cnt_reg   <= 16'd0;
         frame_seq_reg <= 16'd0;
         frame_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               // cfg is only sampled here, so len/gap stay fixed for the frame
               if (cfg[0] && link_up) begin
                  state_reg    <= SEND;
                  len_reg      <= (cfg[15:8] == 8'd0) ? 8'd1 : cfg[15:8];
                  gap_reg      <= cfg[31:16];
                  beat_idx_reg <= 8'd0;
               end
            end
            SEND: begin
               // enable/link are deliberately ignored: a frame always completes
               if (m_axis_tready) begin
                  if (last_beat) begin
                     beat_idx_reg  <= 8'd0;
                     frame_seq_reg <= frame_seq_reg + 16'd1;
                     frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
                     gap_cnt_reg   <= 16'd0;
                     state_reg     <= (gap_reg != 16'd0) ? GAP : IDLE;
                  end else begin
                     beat_idx_reg <= beat_idx_reg + 8'd1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_reg == gap_reg - 16'd1) begin
                  state_reg <= IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 16'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // All outputs decode registered state only; tready never reaches tvalid.
   assign m_axis_tvalid = (state_reg == SEND);
   assign m_axis_tlast  = (state_reg == SEND) && last_beat;
   assign m_axis_tkeep  = '1;
   assign busy          = (state_reg == SEND) || (state_reg == GAP);
   assign frame_cnt     = frame_cnt_reg;

   // Payload word {frame_seq, zero-extended beat_idx} replicated across tdata
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH / 32; gi++) begin : g_rep
         assign m_axis_tdata[gi*32 +: 32] = {frame_seq_reg, 8'h00, beat_idx_reg};
      end
   endgenerate

`ifdef TX_GEN_STALL_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_reg;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         stall_cnt_reg <= '0;
      end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

endmodule
